fft_frame_loader: RTL
=====================

# fft_frame_loader

Serial-to-parallel input stage for the 8-point real-input FFT core. It accepts one IEEE-754 single-precision sample per handshake and packs eight samples into a 256-bit frame. It presents the frame to the combinational FFT core through a valid/ready handshake. A fill buffer and a hold buffer let the next frame stream in while the core's consumer still holds the current one.

## Interface
- `NPTS`, 8, samples per frame; only 8 is supported.
- `DW`, 32, sample width (IEEE-754 single).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s_valid`  in  1  a sample is offered.
- `s_ready`  out  1  loader accepts the sample this cycle.
- `s_data`  in  32  sample, float32 bit pattern.
- `flush`  in  1  discards the partially filled frame.
- `frame`  out  256  packed frame; sample 0 in [255:224], sample 7 in [31:0].
- `frame_valid`  out  1  `frame` holds a complete frame.
- `frame_ready`  in  1  downstream takes the frame.
- `nan_seen`  out  1  sticky; an accepted sample was NaN.
- `frames_out`  out  16  count of frames handed off; wraps.

## Operation
- Accept occurs when `s_valid && s_ready`. Hand-off occurs when `frame_valid && frame_ready`.
- Fill index `idx` runs 0..7. An accepted sample is written to fill slot `idx`, which is bit slice [255-32*idx -: 32], and `idx` increments.
- States:
  - FILL: `s_ready` = !`flush`.
    - Accepting with `idx`==7 while the hold buffer is empty, or is being handed off in the same cycle, copies the fill buffer plus this sample into hold. It then sets `idx`=0 and stays in FILL.
    - Accepting with `idx`==7 while hold is occupied and not handing off goes to PEND, with the fill buffer complete.
  - PEND: `s_ready`=0. On a hand-off, the fill buffer is copied to hold, `idx` is set to 0 and the state returns to FILL. `frame_valid` stays high without a gap.
- `flush`:
  - In FILL, sets `idx`=0 and blocks acceptance that cycle. `flush` wins over `s_valid`.
  - In PEND, discards the completed fill frame and returns to FILL.
  - Never touches the hold buffer or `frame_valid`.
- The hold buffer is stable while `frame_valid && !frame_ready`. `frame` holds its last value after a hand-off and is don't-care while `frame_valid`=0.
- A NaN is exponent 8'hFF with a mantissa != 0. An accepted NaN sets `nan_seen`, which clears only on reset. The sample is still packed unmodified, and infinities pass through unflagged.
- `frames_out` increments on each hand-off and wraps 16'hFFFF→0.

## Timing
- Reset values:
  - `s_ready`=0 during reset, then 1 from the first cycle after deassertion.
  - `frame_valid`=0, `frame`=0, `nan_seen`=0, `frames_out`=0.
  - State FILL, `idx`=0, both buffers zero.
- Latency: when the 8th sample is accepted at edge N, `frame_valid` rises after edge N, provided hold is free.
- Throughput: one sample per cycle sustained when `frame_ready` is held high. No bubble between frames.
- `s_ready` and `frame_valid` are registered or decoded from state only. There is no combinational path from `frame_ready` or `s_valid` to them.
- Asserting reset mid-frame or mid-PEND drops all data immediately, with no hand-off.

## Structure
- Shared package `fft_pkg`:
  - `FFT_NPTS`=8, `FLOAT_W`=32, `FRAME_W`=256.
  - `loader_state_t` enum {FILL, PEND}.
  - Function `is_nan(logic [31:0])`.
- The FFT core also imports `FRAME_W` from `fft_pkg`.
- Single module, no sub-modules. The fill buffer is an 8-entry register array and the hold buffer is a 256-bit register.

## Test plan
- Reset, then stream 40400000, BF800000, 40800000, 40C00000, 40000000, 40E00000, 41000000, C0400000 with `frame_ready`=1:
  - `frame_valid` is high for exactly one cycle, after the 8th accept.
  - `frame` = that concatenation, MSB first.
  - `frames_out`=1.
- `frame_ready`=0 while sending 16 samples (3F800000 ×8, 40000000 ×8):
  - After 16 accepts, the state is PEND, `s_ready`=0 and `frame` = 3F800000 ×8.
  - Raise `frame_ready`: the next cycle shows 40000000 ×8 with `frame_valid` held high.
  - `frames_out` reaches 2 after both hand-offs.
- Send 5 samples, pulse `flush` together with `s_valid`, then send 8 samples of 40A00000:
  - The flushed sample is not accepted.
  - The frame is all 40A00000.
  - `nan_seen`=0.
- Send a frame containing 7FC00000 and another with 7F800000:
  - `nan_seen`=1 after the first frame, and stays 1 through the second.
  - Both frames are forwarded bit-exact.
- Assert `rst_n`=0 asynchronously mid-PEND:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, a fresh 8-sample frame is assembled correctly.
- Preload `frames_out` to 16'hFFFF via 65535 frames, or force it in simulation, then run one more frame → `frames_out`=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point real-input FFT datapath: frame geometry,
// loader state encoding and float32 classification.
package fft_pkg;

    localparam int FFT_NPTS = 8;
    localparam int FLOAT_W  = 32;
    localparam int FRAME_W  = FFT_NPTS * FLOAT_W;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } loader_state_t;

    // Exponent all ones with a non-zero mantissa; infinities are not NaN.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fft_frame_loader.sv
// Packs eight float32 samples into a 256-bit frame for the FFT core, with a
// fill buffer and a hold buffer so the next frame can stream in during hand-off.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int NPTS = FFT_NPTS,
    parameter int DW   = FLOAT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 flush,
    output logic [NPTS*DW-1:0]   frame,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 nan_seen,
    output logic [15:0]          frames_out
);

    localparam int                IDX_W    = $clog2(NPTS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NPTS - 1);

    loader_state_t          state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [DW-1:0]          fill_reg [NPTS];
    logic [NPTS*DW-1:0]     fill_packed;
    logic [NPTS*DW-1:0]     hold_reg;
    logic                   frame_valid_reg;
    logic                   alive_reg;
    logic                   nan_seen_reg;
    logic [15:0]            frames_out_reg;

    logic                   accept;
    logic                   handoff;
    logic                   last;
    logic                   hold_free;
    logic                   load_hold;

    // alive_reg keeps s_ready low while reset is held and until the first edge after release.
    assign s_ready     = alive_reg && (state_reg == FILL) && !flush;
    assign accept      = s_valid && s_ready;
    assign handoff     = frame_valid_reg && frame_ready;
    assign last        = (idx_reg == LAST_IDX);
    assign hold_free   = !frame_valid_reg || handoff;

    assign frame       = hold_reg;
    assign frame_valid = frame_valid_reg;
    assign nan_seen    = nan_seen_reg;
    assign frames_out  = frames_out_reg;

    // The packed view substitutes the sample being accepted into its slot, so
    // the eighth sample lands in hold on the same edge it is accepted.
    generate
        for (genvar gi = 0; gi < NPTS; gi++) begin : g_fill
            assign fill_packed[NPTS*DW-1-DW*gi -: DW] =
                (accept && (idx_reg == IDX_W'(gi))) ? s_data : fill_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fill_reg[gi] <= '0;
                end else if (accept && (idx_reg == IDX_W'(gi))) begin
                    fill_reg[gi] <= s_data;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load_hold  = 1'b0;
        case (state_reg)
            FILL: begin
                if (flush) begin
                    idx_next = '0;
                end else if (accept) begin
                    idx_next = last ? '0 : idx_reg + 1'b1;
                    if (last) begin
                        if (hold_free) begin
                            load_hold = 1'b1;
                        end else begin
                            state_next = PEND;
                        end
                    end
                end
            end
            PEND: begin
                idx_next = '0;
                if (flush) begin
                    state_next = FILL;
                end else if (handoff) begin
                    load_hold  = 1'b1;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FILL;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg        <= '0;
            frame_valid_reg <= 1'b0;
            alive_reg       <= 1'b0;
            nan_seen_reg    <= 1'b0;
            frames_out_reg  <= '0;
        end else begin
            alive_reg <= 1'b1;
            if (load_hold) begin
                hold_reg <= fill_packed;
            end
            // A reload on the hand-off edge keeps frame_valid high with no gap.
            if (load_hold) begin
                frame_valid_reg <= 1'b1;
            end else if (handoff) begin
                frame_valid_reg <= 1'b0;
            end
            if (handoff) begin
                frames_out_reg <= frames_out_reg + 16'd1;
            end
            if (accept && is_nan(s_data)) begin
                nan_seen_reg <= 1'b1;
            end
        end
    end

endmodule
